// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding and operation-select encodings.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic SEL_ADD = 1'b1;
  localparam logic SEL_SUB = 1'b0;

endpackage : addsub_pkg

// File: rtl/addsub_bit.sv
// One-bit full adder / full subtractor cell; CIN and COUT carry a
// carry when adding and a borrow when subtracting.
module addsub_bit
  import addsub_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic CIN,
  input  logic SEL,
  output logic S,
  output logic COUT
);

  // Sum/difference bit is the same XOR for both operations; only the carry differs.
  always_comb begin
    S    = A ^ B ^ CIN;
    COUT = 1'b0;
    case (SEL)
      SEL_ADD: COUT = (A & B) | (CIN & (A ^ B));
      SEL_SUB: COUT = (~A & B) | (CIN & ~(A ^ B));
      default: COUT = 1'b0;
    endcase
  end

endmodule : addsub_bit

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial unsigned adder/subtractor: one bit per clock, LSB first,
// fixed latency of WIDTH cycles from START to the DONE pulse.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SEL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_r, state_next_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r, b_r, sum_r, sum_next_s, result_r;
  logic             sel_r, cy_r, carry_r, busy_r, done_r;
  logic             load_s, step_s, last_s, s_s, cout_s;

  addsub_bit u_cell (
    .A    (a_r[0]),
    .B    (b_r[0]),
    .CIN  (cy_r),
    .SEL  (sel_r),
    .S    (s_s),
    .COUT (cout_s)
  );

  // New bits enter at the MSB so the register holds the result LSB-aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_next_s = s_s;
    end else begin : g_wn
      assign sum_next_s = {s_s, sum_r[WIDTH-1:1]};
    end
  endgenerate

  // Next-state and datapath control decode.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          load_s       = 1'b1;
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CNT) begin
          last_s       = 1'b1;
          state_next_s = ST_FIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, operand shift registers, counter and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      sum_r    <= '0;
      sel_r    <= 1'b0;
      cy_r     <= 1'b0;
      result_r <= '0;
      carry_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_RUN);
      done_r  <= (state_next_s == ST_FIN);
      if (load_s) begin
        a_r   <= A;
        b_r   <= B;
        sel_r <= SEL;
        cnt_r <= '0;
        cy_r  <= 1'b0;
        sum_r <= '0;
      end else if (step_s) begin
        a_r   <= a_r >> 1;
        b_r   <= b_r >> 1;
        cnt_r <= cnt_r + CW'(1);
        cy_r  <= cout_s;
        sum_r <= sum_next_s;
      end else begin
        a_r <= a_r;
      end
      if (last_s) begin
        result_r <= sum_next_s;
        carry_r  <= cout_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign RESULT = result_r;
  assign CARRY  = carry_r;

endmodule : serial_addsub_ctrl

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH=8): directed corner
// cases plus random operations checked against an arithmetic model.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sel;
  logic [W-1:0] a, b;
  logic         busy, done, carry;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] held_res;
  logic         held_cy;
  time          last_done_t;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .START  (start),
    .SEL    (sel),
    .A      (a),
    .B      (b),
    .BUSY   (busy),
    .DONE   (done),
    .RESULT (result),
    .CARRY  (carry)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic.
  function automatic void model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic c);
    logic [31:0] full;
    if (s) begin
      full = 32'(x) + 32'(y);
      c    = (full >= 32'(1 << W));
    end else begin
      full = 32'(x) - 32'(y);
      c    = (x < y);
    end
    r = full[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation whose START is already driven at the current negedge.
  // mid > 0 pulses START with junk operands at that RUN cycle.
  task automatic body(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input int mid);
    logic [W-1:0] er;
    logic         ec;
    model(s, x, y, er, ec);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      check("busy_run", 32'(busy), 32'd1);
      check("done_run", 32'(done), 32'd0);
      check("res_hold", 32'(result), 32'(held_res));
      check("cy_hold", 32'(carry), 32'(held_cy));
      if (i == mid) begin
        start = 1'b1;
        sel   = ~s;
        a     = W'($urandom);
        b     = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check("done_fin", 32'(done), 32'd1);
    check("busy_fin", 32'(busy), 32'd0);
    check("result", 32'(result), 32'(er));
    check("carry", 32'(carry), 32'(ec));
    held_res    = er;
    held_cy     = ec;
    last_done_t = $time;
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input int mid);
    @(negedge clk);
    start = 1'b1;
    sel   = s;
    a     = x;
    b     = y;
    body(s, x, y, mid);
  endtask

  initial begin
    time t1;
    rst_n    = 1'b0;
    start    = 1'b0;
    sel      = 1'b0;
    a        = '0;
    b        = '0;
    held_res = '0;
    held_cy  = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", 32'(result), 32'd0);
    check("rst_cy", 32'(carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b1, 8'h3C, 8'h15, 0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("idle_res", 32'(result), 32'h51);
    run_op(1'b1, 8'hFF, 8'h01, 0);
    run_op(1'b0, 8'h50, 8'h20, 0);
    run_op(1'b0, 8'h00, 8'h01, 0);
    run_op(1'b1, 8'h80, 8'h80, 3);

    // Back-to-back: START held in FIN launches the next operation.
    run_op(1'b1, 8'h12, 8'h34, 0);
    t1    = last_done_t;
    start = 1'b1;
    sel   = 1'b0;
    a     = 8'h10;
    b     = 8'hA7;
    body(1'b0, 8'h10, 8'hA7, 0);
    check("b2b_gap", 32'((last_done_t - t1) / 10), 32'd9);

    // Reset at RUN cycle 4 aborts without a DONE pulse.
    run_op(1'b1, 8'hC8, 8'h64, 0);
    @(negedge clk);
    start = 1'b1;
    sel   = 1'b1;
    a     = 8'h77;
    b     = 8'h22;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_res", 32'(result), 32'd0);
    check("abort_cy", 32'(carry), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    held_res = '0;
    held_cy  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_done", 32'(done), 32'd0);
    end
    run_op(1'b0, 8'h05, 8'h09, 0);

    for (int n = 0; n < 24; n++) begin
      run_op(1'($urandom), W'($urandom), W'($urandom), (n % 3 == 0) ? 5 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_addsub_ctrl

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..32).
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port START, input, 1 bit, the request to begin an operation, sampled on the CLK rising edge.
REQ-005 The block SHALL have port SEL, input, 1 bit, the operation select: 1 = add, 0 = subtract; sampled with START.
REQ-006 The block SHALL have port A, input, WIDTH bits, the unsigned minuend/addend; sampled with START.
REQ-007 The block SHALL have port B, input, WIDTH bits, the unsigned subtrahend/addend; sampled with START.
REQ-008 The block SHALL have port BUSY, output, 1 bit, high while an operation is in progress.
REQ-009 The block SHALL have port DONE, output, 1 bit, a one-cycle pulse marking that RESULT and CARRY are valid.
REQ-010 The block SHALL have port RESULT, output, WIDTH bits, giving A+B or A-B modulo 2^WIDTH.
REQ-011 The block SHALL have port CARRY, output, 1 bit, giving the carry-out for add or the borrow-out for subtract.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and FIN.
REQ-013 In IDLE or FIN with START=1 at an edge, the block SHALL latch A, B and SEL, clear the bit counter and the internal carry/borrow bit, and enter RUN.
REQ-014 In RUN, the block SHALL process one bit per cycle, LSB first, through a single 1-bit add/sub cell fed by the latched A bit, B bit and the internal carry/borrow bit.
REQ-015 In RUN, each edge SHALL shift the cell's sum/difference bit into an internal shift register and store the cell's carry/borrow output.
REQ-016 After the WIDTH-th RUN edge, the block SHALL enter FIN, and at that same edge SHALL load RESULT from the completed shift register and CARRY from the final carry/borrow.
REQ-017 In FIN, DONE SHALL be 1 for exactly one cycle.
REQ-018 From FIN, the block SHALL return to IDLE unless START=1, in which case it SHALL enter RUN per REQ-013, allowing back-to-back operation.
REQ-019 Latency SHALL be fixed: if START is sampled at edge T0, DONE is high in the cycle after edge T0+WIDTH.
REQ-020 BUSY SHALL be 1 exactly while the state is RUN.
REQ-021 START while in RUN SHALL be ignored, with no effect on the operands or the counter.
REQ-022 RESULT and CARRY SHALL change only at the REQ-016 edge or on reset, and SHALL hold between operations.
REQ-023 Subtract SHALL compute A-B with an initial borrow of 0; on underflow, RESULT SHALL wrap mod 2^WIDTH and CARRY SHALL be 1 (i.e. CARRY=1 iff A<B).
REQ-024 Add SHALL compute A+B with an initial carry of 0; CARRY SHALL be 1 iff A+B >= 2^WIDTH.
REQ-025 For WIDTH=1, the operation SHALL complete after one RUN cycle with identical protocol.

Reset
REQ-026 Asserting RST_N=0 SHALL immediately force state IDLE and BUSY=0, DONE=0, RESULT=0, CARRY=0, and clear the counter, operand registers and carry bit, independent of CLK.
REQ-027 A reset during RUN SHALL abort the operation with no DONE pulse; the first START after deassertion SHALL start cleanly.

Structure
REQ-028 The state enumeration and the SEL encodings SEL_ADD=1 and SEL_SUB=0 SHALL reside in shared package addsub_pkg.
REQ-029 The 1-bit cell SHALL be a separate combinational sub-module, addsub_bit, with inputs A, B, CIN (carry or borrow in) and SEL, and outputs S and COUT.
REQ-030 The controller SHALL contain the FSM, the bit counter ($clog2(WIDTH+1) bits), the operand shift registers and the output registers.

Verification (WIDTH=8)
REQ-031 The bench SHALL cover: SEL=1, A=0x3C, B=0x15, START at T0 -> BUSY for 8 cycles, DONE after T8 with RESULT=0x51, CARRY=0.
REQ-032 The bench SHALL cover: SEL=1, A=0xFF, B=0x01 -> RESULT=0x00, CARRY=1; and SEL=0, A=0x50, B=0x20 -> RESULT=0x30, CARRY=0.
REQ-033 The bench SHALL cover: SEL=0, A=0x00, B=0x01 -> RESULT=0xFF, CARRY=1.
REQ-034 The bench SHALL cover: START pulsed mid-RUN with different A/B -> ignored, with the original result delivered on schedule.
REQ-035 The bench SHALL cover: START held high in FIN with a new operation -> the next DONE exactly 9 cycles after the previous one, with the correct second result.
REQ-036 The bench SHALL cover: RST_N low at RUN cycle 4 -> all outputs 0 immediately, no DONE, and a subsequent operation correct.
